dc_replay_queue: RTL and testbench

DC_REPLAY_QUEUE -- requirements
Module: dc_replay_queue

---
 rtl/dc_replay_queue.sv | 196 +++++++++++++++++++
 tb/tb_dc_replay_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dc_replay_queue.sv
// Replay queue in front of the directory pipeline: requests that collide with a
// busy TSHR or an older parked request wait here until that TSHR entry is released.
module dc_replay_queue #(
    parameter int ADDR_WIDTH     = 32,
    parameter int PAYLOAD_WIDTH  = 64,
    parameter int DEPTH          = 8,
    parameter int TSHR_IDX_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        in_address,
    input  logic [PAYLOAD_WIDTH-1:0]     in_payload,
    input  logic                         in_tshr_hit,
    input  logic [TSHR_IDX_WIDTH-1:0]    in_tshr_index,
    input  logic                         rel_valid,
    input  logic [TSHR_IDX_WIDTH-1:0]    rel_index,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_WIDTH-1:0]        out_address,
    output logic [PAYLOAD_WIDTH-1:0]     out_payload,
    output logic                         out_replayed,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]          valid_q, valid_d, waiting_q, waiting_d;
    logic [TSHR_IDX_WIDTH-1:0] tshr_q [DEPTH];
    logic [TSHR_IDX_WIDTH-1:0] tshr_d [DEPTH];
    logic [ADDR_WIDTH-1:0]     addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]     addr_d [DEPTH];
    logic [PAYLOAD_WIDTH-1:0]  payload_q [DEPTH];
    logic [PAYLOAD_WIDTH-1:0]  payload_d [DEPTH];
    // age_q[i][j] set means slot i was allocated before slot j
    logic [DEPTH-1:0]          age_q [DEPTH];
    logic [DEPTH-1:0]          age_d [DEPTH];

    logic                      out_valid_q, out_valid_d, out_replayed_q, out_replayed_d;
    logic [ADDR_WIDTH-1:0]     out_address_q, out_address_d;
    logic [PAYLOAD_WIDTH-1:0]  out_payload_q, out_payload_d;
    logic [OCC_W-1:0]          occupancy_q, occupancy_d;

    logic [DEPTH-1:0]          eligible, addr_match, free_oh, replay_oh, young_oh;
    logic                      eligible_any, out_free, accept, collide;
    logic                      park, direct, replay, free_found;
    logic [TSHR_IDX_WIDTH-1:0] young_tshr, park_tshr;
    logic                      young_waiting, park_waiting;
    logic [ADDR_WIDTH-1:0]     replay_addr;
    logic [PAYLOAD_WIDTH-1:0]  replay_payload;

    assign full         = &valid_q;
    assign out_valid    = out_valid_q;
    assign out_address  = out_address_q;
    assign out_payload  = out_payload_q;
    assign out_replayed = out_replayed_q;
    assign occupancy    = occupancy_q;

    always_comb begin
        out_free     = !out_valid_q || out_ready;
        eligible     = valid_q & ~waiting_q;
        eligible_any = |eligible;
        in_ready     = !full && !eligible_any && out_free;
        accept       = in_valid && in_ready;
        for (int i = 0; i < DEPTH; i++) begin
            addr_match[i] = valid_q[i] && (addr_q[i] == in_address);
        end
        collide = in_tshr_hit || (|addr_match);
        park    = accept && collide;
        direct  = accept && !collide;
        replay  = eligible_any && out_free;

        free_oh    = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end

        // Oldest eligible slot replays; youngest matching slot donates its TSHR link
        replay_oh = '0;
        young_oh  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            replay_oh[i] = eligible[i];
            young_oh[i]  = addr_match[i];
            for (int k = 0; k < DEPTH; k++) begin
                if (k != i) begin
                    if (eligible[k] && age_q[k][i]) replay_oh[i] = 1'b0;
                    if (addr_match[k] && age_q[i][k]) young_oh[i] = 1'b0;
                end
            end
        end

        young_tshr     = '0;
        young_waiting  = 1'b0;
        replay_addr    = '0;
        replay_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (young_oh[i]) begin
                young_tshr    = young_tshr | tshr_q[i];
                young_waiting = young_waiting | waiting_q[i];
            end
            if (replay_oh[i]) begin
                replay_addr    = replay_addr | addr_q[i];
                replay_payload = replay_payload | payload_q[i];
            end
        end
        park_tshr    = in_tshr_hit ? in_tshr_index : young_tshr;
        park_waiting = (in_tshr_hit || young_waiting) && !(rel_valid && (rel_index == park_tshr));
    end

    always_comb begin
        valid_d   = valid_q;
        waiting_d = waiting_q;
        tshr_d    = tshr_q;
        addr_d    = addr_q;
        payload_d = payload_q;
        age_d     = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rel_valid && valid_q[i] && (tshr_q[i] == rel_index)) waiting_d[i] = 1'b0;
            if (replay && replay_oh[i]) valid_d[i] = 1'b0;
            if (park && free_oh[i]) begin
                valid_d[i]   = 1'b1;
                waiting_d[i] = park_waiting;
                tshr_d[i]    = park_tshr;
                addr_d[i]    = in_address;
                payload_d[i] = in_payload;
                age_d[i]     = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != i) age_d[j][i] = valid_q[j];
                end
            end
        end

        out_valid_d    = out_valid_q;
        out_address_d  = out_address_q;
        out_payload_d  = out_payload_q;
        out_replayed_d = out_replayed_q;
        if (out_free) begin
            if (replay) begin
                out_valid_d    = 1'b1;
                out_address_d  = replay_addr;
                out_payload_d  = replay_payload;
                out_replayed_d = 1'b1;
            end else if (direct) begin
                out_valid_d    = 1'b1;
                out_address_d  = in_address;
                out_payload_d  = in_payload;
                out_replayed_d = 1'b0;
            end else begin
                out_valid_d    = 1'b0;
            end
        end

        occupancy_d = occupancy_q;
        case ({park, replay})
            2'b10:   occupancy_d = occupancy_q + OCC_W'(1);
            2'b01:   occupancy_d = occupancy_q - OCC_W'(1);
            default: occupancy_d = occupancy_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q        <= '0;
            waiting_q      <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
            out_valid_q    <= 1'b0;
            out_address_q  <= '0;
            out_payload_q  <= '0;
            out_replayed_q <= 1'b0;
            occupancy_q    <= '0;
        end else begin
            valid_q        <= valid_d;
            waiting_q      <= waiting_d;
            age_q          <= age_d;
            out_valid_q    <= out_valid_d;
            out_address_q  <= out_address_d;
            out_payload_q  <= out_payload_d;
            out_replayed_q <= out_replayed_d;
            occupancy_q    <= occupancy_d;
        end
    end

    // Slot contents are qualified by valid_q, so they need no reset
    always_ff @(posedge clk) begin
        tshr_q    <= tshr_d;
        addr_q    <= addr_d;
        payload_q <= payload_d;
    end

endmodule

// File: tb/tb_dc_replay_queue.sv
// Scoreboard bench for dc_replay_queue: expected outputs are queued as requests
// are driven and compared in order whenever the output handshake completes.
module tb_dc_replay_queue;

    localparam int AW = 32;
    localparam int PW = 64;
    localparam int D  = 8;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [AW-1:0] in_address;
    logic [PW-1:0] in_payload;
    logic          in_tshr_hit;
    logic [TW-1:0] in_tshr_index;
    logic          rel_valid;
    logic [TW-1:0] rel_index;
    logic          out_valid, out_ready, out_replayed, full;
    logic [AW-1:0] out_address;
    logic [PW-1:0] out_payload;
    logic [$clog2(D+1)-1:0] occupancy;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [PW-1:0] payload;
        logic          replayed;
    } exp_t;

    exp_t sbQueue[$];
    int   checkCount = 0;
    int   errorCount = 0;

    dc_replay_queue #(
        .ADDR_WIDTH(AW), .PAYLOAD_WIDTH(PW), .DEPTH(D), .TSHR_IDX_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_address(in_address), .in_payload(in_payload),
        .in_tshr_hit(in_tshr_hit), .in_tshr_index(in_tshr_index),
        .rel_valid(rel_valid), .rel_index(rel_index),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_address(out_address), .out_payload(out_payload),
        .out_replayed(out_replayed), .full(full), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpected(input logic [AW-1:0] a, input logic [PW-1:0] p, input logic r);
        exp_t e;
        e.addr     = a;
        e.payload  = p;
        e.replayed = r;
        sbQueue.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one cycle of stimulus starting just after a rising edge
    task automatic applyStimulus(input logic inV, input logic [AW-1:0] a, input logic [PW-1:0] p,
                                 input logic hit, input logic [TW-1:0] idx,
                                 input logic relV, input logic [TW-1:0] relIdx);
        in_valid      = inV;
        in_address    = a;
        in_payload    = p;
        in_tshr_hit   = hit;
        in_tshr_index = idx;
        rel_valid     = relV;
        rel_index     = relIdx;
        if (inV) begin
            #1;
            checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_tshr_hit = 1'b0;
        rel_valid   = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sb_spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("sb_address", 64'(out_address), 64'(e.addr));
                checkOutput("sb_payload", out_payload, e.payload);
                checkOutput("sb_replayed", 64'(out_replayed), 64'(e.replayed));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_address    = '0;
        in_payload    = '0;
        in_tshr_hit   = 1'b0;
        in_tshr_index = '0;
        rel_valid     = 1'b0;
        rel_index     = '0;
        out_ready     = 1'b1;
        idle(2);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_address", 64'(out_address), 64'd0);
        checkOutput("rst_out_payload", out_payload, 64'd0);
        checkOutput("rst_out_replayed", 64'(out_replayed), 64'd0);
        checkOutput("rst_full", 64'(full), 64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        // No collision: straight through with one cycle of latency
        pushExpected(32'h100, 64'hA000_0000_0000_0001, 1'b0);
        applyStimulus(1'b1, 32'h100, 64'hA000_0000_0000_0001, 1'b0, 3'd0, 1'b0, 3'd0);
        checkOutput("s1_latency_valid", 64'(out_valid), 64'd1);
        checkOutput("s1_occupancy", 64'(occupancy), 64'd0);

        // Park on TSHR 3, then release
        pushExpected(32'h200, 64'hA000_0000_0000_0002, 1'b1);
        applyStimulus(1'b1, 32'h200, 64'hA000_0000_0000_0002, 1'b1, 3'd3, 1'b0, 3'd0);
        checkOutput("s2_parked_occ", 64'(occupancy), 64'd1);
        checkOutput("s2_parked_no_out", 64'(out_valid), 64'd0);
        idle(2);
        checkOutput("s2_still_parked", 64'(occupancy), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, 3'd0, 1'b1, 3'd3);
        checkOutput("s2_not_yet_out", 64'(out_valid), 64'd0);
        idle(1);
        checkOutput("s2_replay_valid", 64'(out_valid), 64'd1);
        checkOutput("s2_occ_back_zero", 64'(occupancy), 64'd0);
        idle(1);

        // Same-address ordering, plus a release that matches no slot
        pushExpected(32'h300, 64'hA000_0000_0000_0031, 1'b1);
        applyStimulus(1'b1, 32'h300, 64'hA000_0000_0000_0031, 1'b1, 3'd2, 1'b0, 3'd0);
        pushExpected(32'h300, 64'hA000_0000_0000_0032, 1'b1);
        applyStimulus(1'b1, 32'h300, 64'hA000_0000_0000_0032, 1'b0, 3'd0, 1'b0, 3'd0);
        checkOutput("s3_two_parked", 64'(occupancy), 64'd2);
        applyStimulus(1'b0, '0, '0, 1'b0, 3'd0, 1'b1, 3'd6);
        idle(1);
        checkOutput("s3_unmatched_rel_occ", 64'(occupancy), 64'd2);
        checkOutput("s3_unmatched_rel_out", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, 3'd0, 1'b1, 3'd2);
        checkOutput("s3_in_ready_blocked", 64'(in_ready), 64'd0);
        idle(1);
        checkOutput("s3_first_out", 64'(out_valid), 64'd1);
        checkOutput("s3_occ_one", 64'(occupancy), 64'd1);
        idle(1);
        checkOutput("s3_second_out", 64'(out_valid), 64'd1);
        checkOutput("s3_occ_zero", 64'(occupancy), 64'd0);
        idle(1);
        checkOutput("s3_drained", 64'(out_valid), 64'd0);

        // Fill every slot on TSHR 1
        for (int i = 0; i < D; i++) begin
            pushExpected(32'h400 + 32'(i * 4), 64'hB000_0000_0000_0000 | 64'(i), 1'b1);
            applyStimulus(1'b1, 32'h400 + 32'(i * 4), 64'hB000_0000_0000_0000 | 64'(i), 1'b1, 3'd1, 1'b0, 3'd0);
        end
        checkOutput("s4_full", 64'(full), 64'd1);
        checkOutput("s4_occ_full", 64'(occupancy), 64'(D));
        checkOutput("s4_in_ready_full", 64'(in_ready), 64'd0);
        in_valid   = 1'b1;
        in_address = 32'h999;
        in_payload = 64'hDEAD;
        idle(1);
        in_valid = 1'b0;
        checkOutput("s4_reject_occ", 64'(occupancy), 64'(D));
        applyStimulus(1'b0, '0, '0, 1'b0, 3'd0, 1'b1, 3'd1);
        checkOutput("s4_not_yet_out", 64'(out_valid), 64'd0);
        idle(1);
        checkOutput("s4_full_drops", 64'(full), 64'd0);
        checkOutput("s4_occ_after_first", 64'(occupancy), 64'(D - 1));
        idle(D);
        checkOutput("s4_drained_occ", 64'(occupancy), 64'd0);
        checkOutput("s4_drained_out", 64'(out_valid), 64'd0);

        // Park and release of the same TSHR in one cycle
        pushExpected(32'h500, 64'hA000_0000_0000_0005, 1'b1);
        applyStimulus(1'b1, 32'h500, 64'hA000_0000_0000_0005, 1'b1, 3'd5, 1'b1, 3'd5);
        checkOutput("s5_parked_occ", 64'(occupancy), 64'd1);
        checkOutput("s5_no_out_yet", 64'(out_valid), 64'd0);
        idle(1);
        checkOutput("s5_replay_valid", 64'(out_valid), 64'd1);
        checkOutput("s5_replay_flag", 64'(out_replayed), 64'd1);
        checkOutput("s5_occ_zero", 64'(occupancy), 64'd0);
        idle(1);

        // Backpressure hold, then reset discards parked and output requests
        applyStimulus(1'b1, 32'h700, 64'hA000_0000_0000_0007, 1'b1, 3'd7, 1'b0, 3'd0);
        out_ready = 1'b0;
        pushExpected(32'h600, 64'hA000_0000_0000_0006, 1'b0);
        applyStimulus(1'b1, 32'h600, 64'hA000_0000_0000_0006, 1'b0, 3'd0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("s6_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("s6_hold_address", 64'(out_address), 64'h600);
            checkOutput("s6_hold_payload", out_payload, 64'hA000_0000_0000_0006);
            idle(1);
        end
        checkOutput("s6_occ_before_rst", 64'(occupancy), 64'd1);
        reset = 1'b1;
        #1;
        sbQueue.delete();
        checkOutput("s6_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("s6_rst_occupancy", 64'(occupancy), 64'd0);
        idle(1);
        reset     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 3'd0, 1'b1, 3'd7);
        idle(3);
        checkOutput("s6_nothing_emitted", 64'(out_valid), 64'd0);
        checkOutput("s6_occ_stays_zero", 64'(occupancy), 64'd0);

        pushExpected(32'h800, 64'hA000_0000_0000_0008, 1'b0);
        applyStimulus(1'b1, 32'h800, 64'hA000_0000_0000_0008, 1'b0, 3'd0, 1'b0, 3'd0);
        idle(2);
        checkOutput("sb_all_drained", 64'(sbQueue.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
